// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: streams words from a valid/ready source into the DMA write port
// while holding the CPU. Optional checksum verification is enabled by INST_LOADER_CSUM_EN.
module inst_mem_loader #(
  parameter int unsigned INST_WIDTH      = 32,
  parameter int unsigned INST_ADDR_WIDTH = 32,
  parameter int unsigned NUM_WORDS       = 128
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst_n,
  input  logic                       load_start,
  input  logic [INST_ADDR_WIDTH-1:0] load_base,
  input  logic [INST_ADDR_WIDTH-1:0] load_len,
  input  logic                       load_abort,
`ifdef INST_LOADER_CSUM_EN
  input  logic [INST_WIDTH-1:0]      exp_csum,
`endif
  input  logic                       s_valid,
  input  logic [INST_WIDTH-1:0]      s_data,
  output logic                       s_ready,
  output logic [INST_ADDR_WIDTH-1:0] dma_inst_mem_waddr,
  output logic [INST_WIDTH-1:0]      dma_inst_mem_wdata,
  output logic                       inst_mem_write,
  output logic                       cpu_hold,
  output logic                       load_busy,
  output logic                       load_done,
  output logic                       load_err
);

  localparam int unsigned AW = INST_ADDR_WIDTH;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [AW:0] NumWordsExt = (AW + 1)'(NUM_WORDS);

  logic [1:0]            state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [AW-1:0]         rem_q, rem_d;
  logic [AW-1:0]         waddr_q, waddr_d;
  logic [INST_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;

  logic                  hs;
  logic                  csum_mismatch;
  logic [AW:0]           end_addr;

  // One bit wider than the operands so base + len can never wrap past the check.
  assign end_addr = {1'b0, load_base} + {1'b0, load_len};

  assign s_ready = (state_q == StLoad) && (rem_q != '0);
  assign hs      = s_valid && s_ready;

`ifdef INST_LOADER_CSUM_EN
  logic [INST_WIDTH-1:0] csum_q, csum_d;
  logic [INST_WIDTH-1:0] exp_q, exp_d;

  always_comb begin
    csum_d = csum_q;
    exp_d  = exp_q;
    if (state_q == StIdle && load_start) begin
      csum_d = '0;
      exp_d  = exp_csum;
    end else if (hs) begin
      csum_d = csum_q + s_data;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      csum_q <= '0;
      exp_q  <= '0;
    end else begin
      csum_q <= csum_d;
      exp_q  <= exp_d;
    end
  end

  assign csum_mismatch = (state_q == StDone) && (csum_q != exp_q);
`else
  assign csum_mismatch = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (load_start) begin
          addr_d = load_base;
          rem_d  = load_len;
          err_d  = 1'b0;
          if (end_addr > NumWordsExt) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (load_len == '0) begin
            state_d = StDone;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (hs) begin
          wr_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = s_data;
          addr_d  = addr_q + AW'(1);
          rem_d   = rem_q - AW'(1);
          if (rem_q == AW'(1)) begin
            state_d = StDone;
          end
        end
        // Abort wins over completion; a same-cycle handshake still writes.
        if (load_abort) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (csum_mismatch) begin
          err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  assign dma_inst_mem_waddr = waddr_q;
  assign dma_inst_mem_wdata = wdata_q;
  assign inst_mem_write     = wr_q;
  assign load_busy          = (state_q != StIdle);
  assign load_done          = (state_q == StDone);
  // Hold also covers the trailing write cycle after an abort returns to idle.
  assign cpu_hold           = (state_q != StIdle) || wr_q;
  assign load_err           = err_q || csum_mismatch;

endmodule
